// File: rtl/debounce_enable_gen.sv
// Synchronizes and debounces a raw button level, emitting a one-cycle active-low enable strobe plus toggle bit per confirmed press.
// Latency: strobe at posedge SYNC_STAGES+1+DEBOUNCE_CYCLES after a stable rise; level falls the same distance after a stable fall.
// Backpressure: none; the strobe is fire-and-forget and the downstream flop must accept it.
module debounce_enable_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int PCNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              raw_in,
  output logic              en_n,
  output logic              d_out,
  output logic              level,
  output logic [PCNT_W-1:0] press_cnt
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               en_n_d;
  logic               d_out_d;
  logic               level_d;
  logic [PCNT_W-1:0]  press_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Every output is a flop so the negedge consumer gets half a cycle of setup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      en_n      <= 1'b1;
      d_out     <= 1'b0;
      level     <= 1'b0;
      press_cnt <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      en_n      <= en_n_d;
      d_out     <= d_out_d;
      level     <= level_d;
      press_cnt <= press_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    en_n_d      = 1'b1;
    d_out_d     = d_out;
    level_d     = level;
    press_cnt_d = press_cnt;

    case (state_q)
      IDLE: begin
        if (sync_in) begin
          state_d = WAIT_PRESS;
          cnt_d   = '0;
        end
      end

      WAIT_PRESS: begin
        if (!sync_in) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // d_out flips together with the strobe so the capture sees the new value.
          state_d     = PRESSED;
          en_n_d      = 1'b0;
          d_out_d     = ~d_out;
          level_d     = 1'b1;
          press_cnt_d = press_cnt + PCNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PRESSED: begin
        if (!sync_in) begin
          state_d = WAIT_RELEASE;
          cnt_d   = '0;
        end
      end

      WAIT_RELEASE: begin
        if (sync_in) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_debounce_enable_gen.sv
// Directed bench for debounce_enable_gen; expected strobes are queued at stimulus time and matched when en_n falls.
module tb_debounce_enable_gen;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int CNT_W           = 16;
  localparam int PCNT_W          = 8;
  localparam int LAT             = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;

  logic              clk;
  logic              rst;
  logic              raw_in;
  logic              en_n;
  logic              d_out;
  logic              level;
  logic [PCNT_W-1:0] press_cnt;

  typedef struct {
    int                cyc;
    logic              d;
    logic [PCNT_W-1:0] cnt;
  } exp_t;

  exp_t              exp_q[$];
  int                checks   = 0;
  int                failures = 0;
  int                cyc      = 0;
  int                strobes  = 0;
  logic              d_m;
  logic [PCNT_W-1:0] p_m;

  debounce_enable_gen #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .PCNT_W         (PCNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .raw_in   (raw_in),
    .en_n     (en_n),
    .d_out    (d_out),
    .level    (level),
    .press_cnt(press_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every low en_n cycle must consume exactly one queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && en_n !== 1'b1) begin
      strobes++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe_cycle", cyc, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("strobe_d_out", {31'd0, d_out}, {31'd0, e.d});
        check("strobe_press_cnt", {24'd0, press_cnt}, {24'd0, e.cnt});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    d_m = 1'b0;
    p_m = '0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic do_press(input bit full);
    int t0;
    raw_in = 1'b1;
    t0     = cyc;
    d_m    = ~d_m;
    p_m    = p_m + 8'd1;
    exp_q.push_back('{t0 + LAT, d_m, p_m});
    tick(LAT - 1);
    if (full) check("press_en_n_before", {31'd0, en_n}, 32'd1);
    tick(2);
    if (full) begin
      check("press_en_n_after", {31'd0, en_n}, 32'd1);
      check("press_level", {31'd0, level}, 32'd1);
      check("press_d_out", {31'd0, d_out}, {31'd0, d_m});
      check("press_cnt", {24'd0, press_cnt}, {24'd0, p_m});
    end
  endtask

  task automatic do_release(input bit full);
    raw_in = 1'b0;
    tick(LAT - 1);
    if (full) check("release_level_before", {31'd0, level}, 32'd1);
    tick(1);
    check("release_level_after", {31'd0, level}, 32'd0);
  endtask

  initial begin
    int t0;
    int s0;
    raw_in = 1'b0;
    rst    = 1'b1;
    d_m    = 1'b0;
    p_m    = '0;

    // 1: asynchronous reset before any clock edge
    #2 rst = 1'b0;
    #1;
    check("reset_en_n", {31'd0, en_n}, 32'd1);
    check("reset_d_out", {31'd0, d_out}, 32'd0);
    check("reset_level", {31'd0, level}, 32'd0);
    check("reset_press_cnt", {24'd0, press_cnt}, 32'd0);
    tick(2);
    rst = 1'b1;
    tick(2);

    // 2: clean press and release
    do_press(1'b1);
    do_release(1'b1);
    tick(3);

    // 3: short bounces in IDLE
    raw_in = 1'b1; tick(3);
    raw_in = 1'b0; tick(1);
    raw_in = 1'b1; tick(2);
    raw_in = 1'b0; tick(10);
    check("bounce_level", {31'd0, level}, 32'd0);
    check("bounce_press_cnt", {24'd0, press_cnt}, {24'd0, p_m});
    check("bounce_en_n", {31'd0, en_n}, 32'd1);

    // 4: short drop while pressed, then a real release
    do_press(1'b1);
    tick(3);
    raw_in = 1'b0; tick(2);
    raw_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("release_bounce_level", {31'd0, level}, 32'd1);
    end
    do_release(1'b1);
    check("release_bounce_cnt", {24'd0, press_cnt}, {24'd0, p_m});
    tick(3);

    // 5: toggle and wrap over 256 presses
    do_reset();
    s0 = strobes;
    for (int i = 0; i < 256; i++) begin
      do_press(1'b0);
      if (i == 254) check("wrap_cnt_255", {24'd0, press_cnt}, 32'd255);
      do_release(1'b0);
      tick(1);
    end
    check("wrap_cnt_0", {24'd0, press_cnt}, 32'd0);
    check("wrap_d_out", {31'd0, d_out}, 32'd0);
    check("wrap_strobes", strobes - s0, 32'd256);

    // 6: reset mid-debounce aborts, then a full-latency strobe follows
    do_reset();
    raw_in = 1'b1;
    t0     = cyc;
    tick(4);
    @(posedge clk);
    #1 rst = 1'b0;
    d_m = 1'b0;
    p_m = '0;
    check("abort_en_n", {31'd0, en_n}, 32'd1);
    check("abort_level", {31'd0, level}, 32'd0);
    tick(2);
    rst = 1'b1;
    t0  = cyc;
    d_m = 1'b1;
    p_m = 8'd1;
    exp_q.push_back('{t0 + LAT, d_m, p_m});
    tick(LAT + 2);
    check("abort_d_out", {31'd0, d_out}, 32'd1);
    check("abort_press_cnt", {24'd0, press_cnt}, 32'd1);
    check("abort_level_after", {31'd0, level}, 32'd1);
    raw_in = 1'b0;
    tick(LAT + 3);

    check("missing_strobes", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
